// File: rtl/gayle_sector_xfer.sv
// Sector-transfer sequencer for the Gayle IDE data port: steers CPU/host word strobes onto
// gayle_fifo, counts 256-word sectors and produces ATA BSY/DRQ status plus the completion irq.
module gayle_sector_xfer (
    input  logic       clk,
    input  logic       clk7_en,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_sectors,
    input  logic       abort,
    input  logic       irq_ack,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic       hst_rd,
    input  logic       hst_wr,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    input  logic       fifo_last_in,
    input  logic       fifo_last_out,
    output logic       fifo_rd,
    output logic       fifo_wr,
    output logic       fifo_clr,
    output logic       bsy,
    output logic       drq,
    output logic       irq,
    output logic       hst_req,
    output logic [8:0] sectors_left
);

    typedef enum logic [2:0] {
        StIdle,
        StHwait,
        StCxfer,
        StCheck,
        StHdrain
    } state_e;

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic [8:0] left_q, left_d;
    logic       irq_q, irq_d;
    logic       clr_q, clr_d;
    logic       bsy_q, drq_q, hreq_q;
    logic       irq_set;
    logic       left_dec;

    // Strobes are routed by the latched direction; anything outside the owning state is dropped.
    always_comb begin
        fifo_rd = 1'b0;
        fifo_wr = 1'b0;
        if (clk7_en) begin
            if (dir_q) begin
                fifo_wr = hst_wr && (state_q == StHwait);
                fifo_rd = cpu_rd && (state_q == StCxfer);
            end else begin
                fifo_wr = cpu_wr && (state_q == StCxfer);
                fifo_rd = hst_rd && (state_q == StHdrain);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        left_d   = left_q;
        irq_d    = irq_q;
        clr_d    = 1'b0;
        irq_set  = 1'b0;
        left_dec = 1'b0;

        case (state_q)
            StHwait: begin
                if (fifo_full) begin
                    state_d = StCxfer;
                    irq_set = 1'b1;
                end
            end
            StCxfer: begin
                if (dir_q) begin
                    if (fifo_rd && fifo_last_out) begin
                        left_dec = 1'b1;
                        state_d  = StCheck;
                    end
                end else if (fifo_wr && fifo_last_in) begin
                    state_d = StHdrain;
                end
            end
            StCheck: begin
                // One idle cycle so fifo_full reflects the words left after the sector boundary.
                if (left_q == 9'd0) begin
                    state_d = StIdle;
                end else if (fifo_full) begin
                    state_d = StCxfer;
                    irq_set = 1'b1;
                end else begin
                    state_d = StHwait;
                end
            end
            StHdrain: begin
                if (fifo_empty) begin
                    left_dec = 1'b1;
                    irq_set  = 1'b1;
                    state_d  = (left_q <= 9'd1) ? StIdle : StCxfer;
                end
            end
            default: ;
        endcase

        if (left_dec && (left_q != 9'd0)) begin
            left_d = left_q - 9'd1;
        end

        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end

        if (abort) begin
            state_d = StIdle;
            left_d  = 9'd0;
            irq_d   = 1'b0;
            clr_d   = 1'b1;
        end else if (cmd_start) begin
            state_d = cmd_dir ? StHwait : StCxfer;
            dir_d   = cmd_dir;
            left_d  = {cmd_sectors == 8'd0, cmd_sectors};
            irq_d   = 1'b0;
            clr_d   = 1'b1;
        end
    end

    // Status flops are loaded from the next state so they always match state_q.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state_q <= StIdle;
                dir_q   <= 1'b0;
                left_q  <= 9'd0;
                irq_q   <= 1'b0;
                clr_q   <= 1'b0;
                bsy_q   <= 1'b0;
                drq_q   <= 1'b0;
                hreq_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                left_q  <= left_d;
                irq_q   <= irq_d;
                clr_q   <= clr_d;
                bsy_q   <= (state_d == StHwait) || (state_d == StCheck) || (state_d == StHdrain);
                drq_q   <= (state_d == StCxfer);
                hreq_q  <= (state_d == StHwait) || (state_d == StHdrain);
            end
        end
    end

    assign fifo_clr     = clr_q;
    assign bsy          = bsy_q;
    assign drq          = drq_q;
    assign irq          = irq_q;
    assign hst_req      = hreq_q;
    assign sectors_left = left_q;

endmodule
